cache_tag_array: RTL and testbench

CACHE_TAG_ARRAY -- requirements
Module: cache_tag_array

---
 rtl/cache_tag_array.sv | 190 +++++++++++++++++++
 tb/tb_cache_tag_array.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_array.sv
// Set-associative cache tag array: per-set tags with valid/dirty bits,
// tree/bit PLRU replacement, one-cycle lookup response and a sequential
// full-array invalidation walk.
//
// state | meaning
// IDLE  | lookups and writes accepted
// FLUSH | clearing set[cnt_q] each cycle, lookups blocked, writes dropped
module cache_tag_array #(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 64,
  parameter  int TAG_W = 21,
  localparam int IW    = $clog2(SETS),
  localparam int WW    = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [IW-1:0]    lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_ready,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAYS-1:0]  rsp_way,
  output logic             rsp_dirty,
  output logic [WW-1:0]    rsp_vic_way,
  output logic             rsp_vic_valid,
  output logic             rsp_vic_dirty,
  output logic [TAG_W-1:0] rsp_vic_tag,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_index,
  input  logic [WW-1:0]    wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic             inv_all,
  output logic             busy
);

  // 1 PLRU bit for 2 ways, 3-bit tree (b0 root, b1 left, b2 right) for 4 ways
  localparam int PW = (WAYS == 4) ? 3 : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;

  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [PW-1:0]    plru_q  [SETS];

  logic             lk_acc, wr_acc;
  logic [WAYS-1:0]  hit_way;
  logic             hit_any, hit_dirty;
  logic [WW-1:0]    hit_idx, vic_way, plru_vic;
  logic [PW-1:0]    plru_hit_nxt, plru_wr_nxt;

  // FSM state and flush counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lk_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        lk_ready = 1'b1;
        cnt_d    = '0;
        if (inv_all) state_d = FLUSH;
      end
      FLUSH: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write in the cycle that starts a flush is dropped; lookups still go
  assign lk_acc = lk_valid && lk_ready;
  assign wr_acc = wr_en && (state_q == IDLE) && !inv_all;

  // Tag compare and victim choice: lowest invalid way, else the PLRU way
  always_comb begin
    hit_way = '0;
    hit_idx = '0;
    vic_way = plru_vic;
    for (int w = 0; w < WAYS; w++)
      hit_way[w] = valid_q[lk_index][w] && (tag_mem[lk_index][w] == lk_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_way[w]) hit_idx = WW'(w);
      if (!valid_q[lk_index][w]) vic_way = WW'(w);
    end
  end

  assign hit_any   = |hit_way;
  assign hit_dirty = |(hit_way & dirty_q[lk_index]);

  if (WAYS == 2) begin : g_plru2
    // Single bit remembers the last way touched; the other one is the victim
    always_comb begin
      plru_vic     = ~plru_q[lk_index];
      plru_hit_nxt = hit_idx;
      plru_wr_nxt  = wr_way;
    end
  end else begin : g_plru4
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
      logic [2:0] r;
      case (w)
        2'd0:    r = {p[2], 1'b1, 1'b1};
        2'd1:    r = {p[2], 1'b0, 1'b1};
        2'd2:    r = {1'b1, p[1], 1'b0};
        default: r = {1'b0, p[1], 1'b0};
      endcase
      return r;
    endfunction

    // Tree PLRU: b0 picks the half, b1/b2 pick the way within it
    always_comb begin
      plru_vic     = plru_q[lk_index][0] ? (plru_q[lk_index][2] ? 2'd3 : 2'd2)
                                         : (plru_q[lk_index][1] ? 2'd1 : 2'd0);
      plru_hit_nxt = plru_touch(plru_q[lk_index], hit_idx);
      plru_wr_nxt  = plru_touch(plru_q[wr_index], wr_way);
    end
  end

  // Valid/dirty/PLRU state; the write's PLRU update is issued last so it wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state_q == FLUSH) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else begin
      if (lk_acc && hit_any) plru_q[lk_index] <= plru_hit_nxt;
      if (wr_acc) begin
        valid_q[wr_index][wr_way] <= wr_valid;
        dirty_q[wr_index][wr_way] <= wr_dirty;
        plru_q[wr_index]          <= plru_wr_nxt;
      end
    end
  end

  // Tag storage carries no reset; an invalid way's tag is never trusted
  always_ff @(posedge clk) begin
    if (wr_acc) tag_mem[wr_index][wr_way] <= wr_tag;
  end

  // Lookup response register, sampled from pre-write contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_way       <= '0;
      rsp_dirty     <= 1'b0;
      rsp_vic_way   <= '0;
      rsp_vic_valid <= 1'b0;
      rsp_vic_dirty <= 1'b0;
      rsp_vic_tag   <= '0;
    end else begin
      rsp_valid <= lk_acc;
      if (lk_acc) begin
        rsp_hit       <= hit_any;
        rsp_way       <= hit_way;
        rsp_dirty     <= hit_dirty;
        rsp_vic_way   <= vic_way;
        rsp_vic_valid <= valid_q[lk_index][vic_way];
        rsp_vic_dirty <= dirty_q[lk_index][vic_way];
        rsp_vic_tag   <= tag_mem[lk_index][vic_way];
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench for cache_tag_array: a 2-way and a 4-way instance share
// the same stimulus; each check names the instance it targets.
module tb_cache_tag_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid, wr_en, wr_valid, wr_dirty, inv_all;
  logic [5:0]  lk_index, wr_index;
  logic [20:0] lk_tag, wr_tag;
  logic [1:0]  wr_way;

  logic        lk_ready_2, rsp_valid_2, rsp_hit_2, rsp_dirty_2, busy_2;
  logic [1:0]  rsp_way_2;
  logic        rsp_vic_way_2, rsp_vic_valid_2, rsp_vic_dirty_2;
  logic [20:0] rsp_vic_tag_2;

  logic        lk_ready_4, rsp_valid_4, rsp_hit_4, rsp_dirty_4, busy_4;
  logic [3:0]  rsp_way_4;
  logic [1:0]  rsp_vic_way_4;
  logic        rsp_vic_valid_4, rsp_vic_dirty_4;
  logic [20:0] rsp_vic_tag_4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_tag_array #(.WAYS(2), .SETS(64), .TAG_W(21)) dut2 (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag), .lk_ready(lk_ready_2),
    .rsp_valid(rsp_valid_2), .rsp_hit(rsp_hit_2), .rsp_way(rsp_way_2), .rsp_dirty(rsp_dirty_2),
    .rsp_vic_way(rsp_vic_way_2), .rsp_vic_valid(rsp_vic_valid_2),
    .rsp_vic_dirty(rsp_vic_dirty_2), .rsp_vic_tag(rsp_vic_tag_2),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way[0]), .wr_tag(wr_tag),
    .wr_valid(wr_valid), .wr_dirty(wr_dirty), .inv_all(inv_all), .busy(busy_2)
  );

  cache_tag_array #(.WAYS(4), .SETS(64), .TAG_W(21)) dut4 (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag), .lk_ready(lk_ready_4),
    .rsp_valid(rsp_valid_4), .rsp_hit(rsp_hit_4), .rsp_way(rsp_way_4), .rsp_dirty(rsp_dirty_4),
    .rsp_vic_way(rsp_vic_way_4), .rsp_vic_valid(rsp_vic_valid_4),
    .rsp_vic_dirty(rsp_vic_dirty_4), .rsp_vic_tag(rsp_vic_tag_4),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag),
    .wr_valid(wr_valid), .wr_dirty(wr_dirty), .inv_all(inv_all), .busy(busy_4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] idx, input logic [1:0] way, input logic [20:0] tag,
                          input logic v, input logic d);
    wr_en = 1'b1; wr_index = idx; wr_way = way; wr_tag = tag; wr_valid = v; wr_dirty = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [5:0] idx, input logic [20:0] tag);
    lk_valid = 1'b1; lk_index = idx; lk_tag = tag;
    tick;
    lk_valid = 1'b0;
    check("rsp_valid_2", {31'b0, rsp_valid_2}, 1);
    check("rsp_valid_4", {31'b0, rsp_valid_4}, 1);
    check("onehot_2", {31'b0, $onehot0(rsp_way_2)}, 1);
    check("onehot_4", {31'b0, $onehot0(rsp_way_4)}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [5:0]  pf_idx [5];
  logic [20:0] pf_tag [5];

  initial begin
    int n;
    int rdy_bad;
    rst = 1'b1;
    lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
    wr_en = 1'b0; wr_index = '0; wr_way = '0; wr_tag = '0; wr_valid = 1'b0; wr_dirty = 1'b0;
    inv_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid_2}, 0);
    check("rst_rsp_hit", {31'b0, rsp_hit_2}, 0);
    check("rst_rsp_way4", {28'b0, rsp_way_4}, 0);
    check("rst_vic_tag4", {11'b0, rsp_vic_tag_4}, 0);
    check("rst_busy", {30'b0, busy_4, busy_2}, 0);
    check("rst_lk_ready", {30'b0, lk_ready_4, lk_ready_2}, 3);
    rst = 1'b0;
    tick;

    // Empty array lookup
    do_lookup(6'd5, 21'h1A);
    check("empty_hit", {31'b0, rsp_hit_2}, 0);
    check("empty_vic_way", {31'b0, rsp_vic_way_2}, 0);
    check("empty_vic_valid", {31'b0, rsp_vic_valid_2}, 0);
    tick;
    check("rsp_valid_idle", {31'b0, rsp_valid_2}, 0);

    // Dirty hit in way 1
    do_write(6'd5, 2'd1, 21'h1A, 1'b1, 1'b1);
    do_lookup(6'd5, 21'h1A);
    check("hit2_hit", {31'b0, rsp_hit_2}, 1);
    check("hit2_way", {30'b0, rsp_way_2}, 2);
    check("hit2_dirty", {31'b0, rsp_dirty_2}, 1);
    check("hit4_way", {28'b0, rsp_way_4}, 4'b0010);
    check("hit4_vic_way", {30'b0, rsp_vic_way_4}, 0);

    // 2-way PLRU: writes way1 then way0 -> victim way1
    do_write(6'd5, 2'd0, 21'h2B, 1'b1, 1'b0);
    do_lookup(6'd5, 21'h77);
    check("p2_miss_hit", {31'b0, rsp_hit_2}, 0);
    check("p2_miss_dirty", {31'b0, rsp_dirty_2}, 0);
    check("p2_vic_way_a", {31'b0, rsp_vic_way_2}, 1);
    check("p2_vic_valid_a", {31'b0, rsp_vic_valid_2}, 1);
    check("p2_vic_dirty_a", {31'b0, rsp_vic_dirty_2}, 1);
    check("p2_vic_tag_a", {11'b0, rsp_vic_tag_2}, 32'h1A);
    check("p4_vic_way_inv", {30'b0, rsp_vic_way_4}, 2);
    check("p4_vic_valid_inv", {31'b0, rsp_vic_valid_4}, 0);
    do_lookup(6'd5, 21'h1A);
    do_lookup(6'd5, 21'h77);
    check("p2_vic_way_b", {31'b0, rsp_vic_way_2}, 0);
    check("p2_vic_tag_b", {11'b0, rsp_vic_tag_2}, 32'h2B);
    check("p2_vic_dirty_b", {31'b0, rsp_vic_dirty_2}, 0);

    // 4-way tree PLRU on set 3
    for (int w = 0; w < 4; w++)
      do_write(6'd3, 2'(w), 21'h100 + 21'(w), 1'b1, (w == 2));
    do_lookup(6'd3, 21'h100);
    check("p4_hit_way0", {28'b0, rsp_way_4}, 4'b0001);
    check("p4_hit_dirty0", {31'b0, rsp_dirty_4}, 0);
    do_lookup(6'd3, 21'h999);
    check("p4_vic_way_a", {30'b0, rsp_vic_way_4}, 2);
    check("p4_vic_valid_a", {31'b0, rsp_vic_valid_4}, 1);
    check("p4_vic_dirty_a", {31'b0, rsp_vic_dirty_4}, 1);
    check("p4_vic_tag_a", {11'b0, rsp_vic_tag_4}, 32'h102);
    do_lookup(6'd3, 21'h102);
    check("p4_hit_dirty2", {31'b0, rsp_dirty_4}, 1);
    do_lookup(6'd3, 21'h999);
    check("p4_vic_way_b", {30'b0, rsp_vic_way_4}, 1);
    check("p4_vic_tag_b", {11'b0, rsp_vic_tag_4}, 32'h101);

    // Same-cycle hit (way0) and write (way2): write's PLRU update wins
    lk_valid = 1'b1; lk_index = 6'd3; lk_tag = 21'h100;
    wr_en = 1'b1; wr_index = 6'd3; wr_way = 2'd2; wr_tag = 21'h102; wr_valid = 1'b1; wr_dirty = 1'b1;
    tick;
    lk_valid = 1'b0; wr_en = 1'b0;
    check("coll_hit_way", {28'b0, rsp_way_4}, 4'b0001);
    do_lookup(6'd3, 21'h999);
    check("coll_vic_way", {30'b0, rsp_vic_way_4}, 1);

    // Same-cycle write and lookup on empty set 7: read-before-write
    lk_valid = 1'b1; lk_index = 6'd7; lk_tag = 21'h3;
    wr_en = 1'b1; wr_index = 6'd7; wr_way = 2'd0; wr_tag = 21'h3; wr_valid = 1'b1; wr_dirty = 1'b0;
    tick;
    lk_valid = 1'b0; wr_en = 1'b0;
    check("rbw_first_2", {31'b0, rsp_hit_2}, 0);
    check("rbw_first_4", {31'b0, rsp_hit_4}, 0);
    do_lookup(6'd7, 21'h3);
    check("rbw_second_2", {30'b0, rsp_way_2}, 1);
    check("rbw_second_4", {28'b0, rsp_way_4}, 1);

    // Top set, all-ones tag
    do_write(6'd63, 2'd1, 21'h1FFFFF, 1'b1, 1'b1);
    do_lookup(6'd63, 21'h1FFFFF);
    check("top_way_2", {30'b0, rsp_way_2}, 2);
    check("top_dirty_2", {31'b0, rsp_dirty_2}, 1);

    // Flush start with a concurrent lookup (served) and write (dropped)
    inv_all = 1'b1; lk_valid = 1'b1; lk_index = 6'd5; lk_tag = 21'h1A;
    wr_en = 1'b1; wr_index = 6'd9; wr_way = 2'd0; wr_tag = 21'h55; wr_valid = 1'b1; wr_dirty = 1'b0;
    tick;
    inv_all = 1'b0; lk_valid = 1'b0; wr_en = 1'b0;
    check("inv_lk_valid", {31'b0, rsp_valid_2}, 1);
    check("inv_lk_way", {30'b0, rsp_way_2}, 2);
    check("inv_busy", {30'b0, busy_4, busy_2}, 3);
    n = 0;
    rdy_bad = 0;
    while (busy_2 && n < 200) begin
      if (lk_ready_2 || lk_ready_4) rdy_bad++;
      if (n == 20) begin
        wr_en = 1'b1; wr_index = 6'd11; wr_way = 2'd0; wr_tag = 21'h66; wr_valid = 1'b1;
        lk_valid = 1'b1; lk_index = 6'd11; lk_tag = 21'h66;
      end
      if (n == 21) begin
        wr_en = 1'b0; lk_valid = 1'b0;
        check("flush_no_rsp", {30'b0, rsp_valid_4, rsp_valid_2}, 0);
      end
      inv_all = (n == 30);
      n++;
      tick;
    end
    inv_all = 1'b0;
    check("flush_cycles", n, 64);
    check("flush_ready_low", rdy_bad, 0);
    check("flush_end_4", {30'b0, busy_4, lk_ready_4}, 1);

    pf_idx[0] = 6'd5;  pf_tag[0] = 21'h1A;
    pf_idx[1] = 6'd3;  pf_tag[1] = 21'h100;
    pf_idx[2] = 6'd63; pf_tag[2] = 21'h1FFFFF;
    pf_idx[3] = 6'd11; pf_tag[3] = 21'h66;
    pf_idx[4] = 6'd9;  pf_tag[4] = 21'h55;
    for (int i = 0; i < 5; i++) begin
      do_lookup(pf_idx[i], pf_tag[i]);
      check($sformatf("post_flush_hit_%0d", i), {30'b0, rsp_hit_4, rsp_hit_2}, 0);
      check($sformatf("post_flush_vv_%0d", i), {30'b0, rsp_vic_valid_4, rsp_vic_valid_2}, 0);
    end

    // Reset in the middle of a flush
    do_write(6'd40, 2'd0, 21'h44, 1'b1, 1'b0);
    do_lookup(6'd40, 21'h44);
    check("pre_rst_hit", {30'b0, rsp_hit_4, rsp_hit_2}, 3);
    inv_all = 1'b1;
    tick;
    inv_all = 1'b0;
    repeat (10) tick;
    check("mid_flush_busy", {31'b0, busy_2}, 1);
    rst = 1'b1;
    #1;
    check("rst_busy_now", {30'b0, busy_4, busy_2}, 0);
    check("rst_ready_now", {30'b0, lk_ready_4, lk_ready_2}, 3);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("after_rst_busy", {30'b0, busy_4, busy_2}, 0);
    do_lookup(6'd40, 21'h44);
    check("after_rst_hit", {30'b0, rsp_hit_4, rsp_hit_2}, 0);

    // Reset while a lookup is pending
    lk_valid = 1'b1; lk_index = 6'd40; lk_tag = 21'h44;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    lk_valid = 1'b0;
    check("abort_rsp_in_rst", {30'b0, rsp_valid_4, rsp_valid_2}, 0);
    rst = 1'b0;
    tick;
    check("abort_rsp_after", {30'b0, rsp_valid_4, rsp_valid_2}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
